// File: rtl/lcd_pkg.sv
// Shared types, command/init constants and default 50 MHz timing for the HD44780 4-bit write sequencer.
package lcd_pkg;

  localparam int unsigned CW_DEF      = 20;
  localparam int unsigned T_PWR_DEF   = 750000;
  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_EN_DEF    = 12;
  localparam int unsigned T_HOLD_DEF  = 1;
  localparam int unsigned T_GAP_DEF   = 50;
  localparam int unsigned T_CMD_DEF   = 2000;
  localparam int unsigned T_CLR_DEF   = 82000;
  localparam int unsigned T_INIT1_DEF = 205000;
  localparam int unsigned T_INIT2_DEF = 5000;

  localparam int unsigned INIT_STEPS  = 4;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_GAP      = 3'd4,
    ST_DELAY    = 3'd5,
    ST_IDLE     = 3'd6
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_req_t;

  // Counter preload for a phase of max(t,1) cycles.
  function automatic int unsigned phase_load(input int unsigned t);
    return (t <= 32'd1) ? 32'd0 : t - 32'd1;
  endfunction

  // Clear and home need the long execution delay.
  function automatic logic is_slow_cmd(input lcd_req_t req);
    return !req.rs && ((req.data == CMD_CLEAR) || (req.data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter shared by all timed phases; oDone is high in the last cycle of a loaded phase.
module lcd_delay_counter #(
  parameter int unsigned CW = 20
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          iLoad,
  input  logic [CW-1:0] iValue,
  output logic          oDone
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (iLoad) begin
      cnt_d    = iValue;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
    // Registered so done lines up with the cycle the count reads zero.
    done_d = active_d && (cnt_d == '0);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign oDone = done_q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780 4-bit bus owner: power-on nibble init, then byte writes split into timed nibble strobes.
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned T_PWR   = T_PWR_DEF,
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_EN    = T_EN_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned T_GAP   = T_GAP_DEF,
  parameter int unsigned T_CMD   = T_CMD_DEF,
  parameter int unsigned T_CLR   = T_CLR_DEF,
  parameter int unsigned T_INIT1 = T_INIT1_DEF,
  parameter int unsigned T_INIT2 = T_INIT2_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oInitDone,
  output logic [3:0] oLCD,
  output logic       oEnable,
  output logic       oRegisterSelect,
  output logic       oReadWrite
);

  lcd_state_e    state_q, state_d;
  logic          pwr_armed_q, pwr_armed_d;
  logic          in_init_q, in_init_d;
  logic [1:0]    init_idx_q, init_idx_d;
  logic          hi_nib_q, hi_nib_d;
  lcd_req_t      req_q, req_d;
  logic [3:0]    lcd_q, lcd_d;
  logic          en_q, en_d;
  logic          rs_q, rs_d;
  logic          ready_q, ready_d;
  logic          init_done_q, init_done_d;

  logic          cnt_load;
  logic [CW-1:0] cnt_value;
  logic          cnt_done;
  int unsigned   delay_len;

  lcd_delay_counter #(.CW(CW)) u_delay (
    .Clock  (Clock),
    .Reset  (Reset),
    .iLoad  (cnt_load),
    .iValue (cnt_value),
    .oDone  (cnt_done)
  );

  // Post-write delay for the nibble or byte currently on the bus.
  always_comb begin
    delay_len = T_CMD;
    if (in_init_q) begin
      if (init_idx_q == 2'd0) begin
        delay_len = T_INIT1;
      end else if (init_idx_q == 2'd1) begin
        delay_len = T_INIT2;
      end
    end else if (is_slow_cmd(req_q)) begin
      delay_len = T_CLR;
    end
  end

  always_comb begin
    state_d     = state_q;
    pwr_armed_d = pwr_armed_q;
    in_init_d   = in_init_q;
    init_idx_d  = init_idx_q;
    hi_nib_d    = hi_nib_q;
    req_d       = req_q;
    lcd_d       = lcd_q;
    en_d        = 1'b0;
    rs_d        = rs_q;
    ready_d     = 1'b0;
    init_done_d = init_done_q;
    cnt_load    = 1'b0;
    cnt_value   = '0;

    case (state_q)
      ST_PWR_WAIT: begin
        // The reset cycle itself counts as the first power-on cycle.
        if (pwr_armed_q ? cnt_done : (T_PWR <= 32'd1)) begin
          state_d    = ST_SETUP;
          in_init_d  = 1'b1;
          init_idx_d = 2'd0;
          hi_nib_d   = 1'b0;
          lcd_d      = INIT_NIB_WAKE;
          rs_d       = 1'b0;
          cnt_load   = 1'b1;
          cnt_value  = CW'(phase_load(T_SETUP));
        end else if (!pwr_armed_q) begin
          pwr_armed_d = 1'b1;
          cnt_load    = 1'b1;
          cnt_value   = CW'(T_PWR - 32'd2);
        end
      end

      ST_SETUP: begin
        if (cnt_done) begin
          state_d   = ST_PULSE;
          en_d      = 1'b1;
          cnt_load  = 1'b1;
          cnt_value = CW'(phase_load(T_EN));
        end
      end

      ST_PULSE: begin
        en_d = 1'b1;
        if (cnt_done) begin
          state_d   = ST_HOLD;
          en_d      = 1'b0;
          cnt_load  = 1'b1;
          cnt_value = CW'(phase_load(T_HOLD));
        end
      end

      ST_HOLD: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          if (!in_init_q && hi_nib_q) begin
            state_d   = ST_GAP;
            cnt_value = CW'(phase_load(T_GAP));
          end else begin
            state_d   = ST_DELAY;
            cnt_value = CW'(phase_load(delay_len));
          end
        end
      end

      ST_GAP: begin
        if (cnt_done) begin
          state_d   = ST_SETUP;
          hi_nib_d  = 1'b0;
          lcd_d     = req_q.data[3:0];
          cnt_load  = 1'b1;
          cnt_value = CW'(phase_load(T_SETUP));
        end
      end

      ST_DELAY: begin
        if (cnt_done) begin
          if (in_init_q && (init_idx_q != 2'(INIT_STEPS - 1))) begin
            state_d    = ST_SETUP;
            init_idx_d = init_idx_q + 2'd1;
            lcd_d      = (init_idx_q + 2'd1 == 2'(INIT_STEPS - 1)) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
            cnt_load   = 1'b1;
            cnt_value  = CW'(phase_load(T_SETUP));
          end else begin
            state_d     = ST_IDLE;
            in_init_d   = 1'b0;
            ready_d     = 1'b1;
            init_done_d = 1'b1;
          end
        end
      end

      ST_IDLE: begin
        ready_d = 1'b1;
        if (iValid && ready_q) begin
          state_d    = ST_SETUP;
          req_d.rs   = iRS;
          req_d.data = iData;
          lcd_d      = iData[7:4];
          rs_d       = iRS;
          hi_nib_d   = 1'b1;
          ready_d    = 1'b0;
          cnt_load   = 1'b1;
          cnt_value  = CW'(phase_load(T_SETUP));
        end
      end

      default: begin
        state_d     = ST_PWR_WAIT;
        pwr_armed_d = 1'b0;
        in_init_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= ST_PWR_WAIT;
      pwr_armed_q <= 1'b0;
      in_init_q   <= 1'b0;
      init_idx_q  <= 2'd0;
      hi_nib_q    <= 1'b0;
      req_q       <= '0;
      lcd_q       <= 4'h0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_armed_q <= pwr_armed_d;
      in_init_q   <= in_init_d;
      init_idx_q  <= init_idx_d;
      hi_nib_q    <= hi_nib_d;
      req_q       <= req_d;
      lcd_q       <= lcd_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign oReady          = ready_q;
  assign oInitDone       = init_done_q;
  assign oLCD            = lcd_q;
  assign oEnable         = en_q;
  assign oRegisterSelect = rs_q;
  assign oReadWrite      = 1'b0;

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Owns the 4-bit HD44780 character-LCD bus on the Spartan-3E board.
- Performs the power-on nibble initialisation, then accepts byte writes (data or command) over a valid/ready handshake.
- Splits each byte into high and low nibbles and drives every enable pulse, setup/hold interval and post-command delay in hardware.
- Replaces software-timed LCD nibble writes issued by the MiniAlu program.

Parameters:
- CW, 20, width of the shared delay counter; every T_* value below must fit in CW bits.
- T_PWR, 750000, power-on wait in cycles (15 ms at 50 MHz).
- T_SETUP, 2, cycles oLCD/oRegisterSelect are stable before oEnable rises.
- T_EN, 12, cycles oEnable is held high.
- T_HOLD, 1, cycles data is held after oEnable falls.
- T_GAP, 50, cycles between the high and low nibble of one byte.
- T_CMD, 2000, post-byte delay for normal writes.
- T_CLR, 82000, post-byte delay for clear/home commands.
- T_INIT1, 205000, delay after init nibble 1.
- T_INIT2, 5000, delay after init nibble 2.

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-low reset
- iValid  in  1  requester has a byte to write
- iRS  in  1  register select for the byte: 0 = command, 1 = data
- iData  in  8  byte to write
- oReady  out  1  sequencer is idle and accepts a byte this cycle
- oInitDone  out  1  power-on init is complete; stays high until reset
- oLCD  out  4  LCD data nibble DB7..DB4
- oEnable  out  1  LCD E strobe
- oRegisterSelect  out  1  LCD RS
- oReadWrite  out  1  LCD R/W; constant 0 (write only)

Behaviour:
- Reset (Reset==0 at a Clock edge) applies the following on that edge regardless of current state, including mid-pulse:
  - oLCD=0, oEnable=0, oRegisterSelect=0, oReadWrite=0, oReady=0, oInitDone=0.
  - State goes to PWR_WAIT and the counter clears.
- All outputs are registered.
- Every timed phase lasts exactly max(T,1) cycles, counted by one shared down-counter.
- States:
  - PWR_WAIT: runs for T_PWR cycles, then INIT_SETUP with init index 0.
  - Init sequence: four single-nibble writes with RS=0. Nibbles are 3, 3, 3, 2. Post-delays are T_INIT1, T_INIT2, T_CMD, T_CMD.
  - Each init write runs SETUP -> PULSE -> HOLD -> DELAY.
  - After the 4th delay: oInitDone=1 and oReady=1 on the same edge; go to IDLE.
  - IDLE: oReady=1. A handshake on iValid&&oReady latches iData and iRS and drops oReady on the next edge. The high nibble is then driven: SETUP(T_SETUP) -> PULSE(T_EN, oEnable=1) -> HOLD(T_HOLD) -> GAP(T_GAP).
  - The low nibble then runs SETUP -> PULSE -> HOLD -> DELAY.
  - DELAY length is T_CLR when iRS==0 and iData is 0x01 or 0x02, otherwise T_CMD.
  - After DELAY: back to IDLE with oReady=1.
- oLCD and oRegisterSelect change only on entry to SETUP. They stay constant through PULSE and HOLD.
- oEnable is high only in PULSE.
- Between bytes, oLCD holds the last nibble and oRegisterSelect holds the last RS.
- iValid outside IDLE is ignored. There is no queue; the requester holds iValid until it sees oReady.
- Back-to-back requests: iValid held high is accepted on the first IDLE cycle. Minimum byte period is 2*(T_SETUP+T_EN+T_HOLD)+T_GAP+T_DELAY+1 cycles.
- iData and iRS are don't-care when iValid==0 or oReady==0.
- Illegal or unreachable state encodings go to PWR_WAIT.

Decomposition:
- Shared package (lcd_pkg):
  - state encoding constants.
  - LCD command constants (CLEAR=8'h01, HOME=8'h02).
  - init nibble constants (4'h3, 4'h2).
  - default timing constants for 50 MHz.
- One sub-module, lcd_delay_counter:
  - CW-bit loadable down-counter with inputs Clock, Reset, iLoad, iValue.
  - Output oDone pulses high in the last cycle of a phase.
  - Same reset polarity as the parent.

Test Plan (simulation parameters: T_PWR=10, T_SETUP=2, T_EN=3, T_HOLD=1, T_GAP=4, T_CMD=6, T_CLR=20, T_INIT1=8, T_INIT2=5):
- Power-on: release Reset, iValid=0 -> no oEnable for 10+2 cycles. Then exactly 4 pulses, each 3 cycles wide, with oLCD=3,3,3,2 and oRegisterSelect=0. oInitDone and oReady rise together after the last T_CMD delay.
- Data write: iData=8'hA5, iRS=1 pulsed with oReady -> two pulses with oLCD=A then 5 and oRegisterSelect=1 throughout. oEnable is low for 1+4+2=7 cycles between the pulses. oReady returns 1+6 cycles after the second pulse falls.
- Clear command: iData=8'h01, iRS=0 -> post-delay is 20 cycles before oReady. Repeat with iRS=1 -> delay is 6. Repeat with 8'h02, iRS=0 -> delay is 20.
- Held iValid: iValid=1 continuously with changing iData (8'h41, 8'h42) -> each byte is accepted only on oReady cycles. oLCD sequence is 4,1,4,2. Data presented while busy is never sampled.
- Reset mid-pulse: assert Reset=0 during PULSE of the high nibble -> next edge gives oEnable=0, oReady=0, oInitDone=0. The full init sequence re-runs after release.
- oReadWrite is 0 in every cycle of all scenarios. oLCD and oRegisterSelect never change while oEnable=1 or during HOLD.
